i2c_xfer_sequencer: RTL and testbench

- Wishbone master that sequences complete I2C transactions on the iicmb I2C master core's register file: CSR=0, DPR=1, CMDR=2, FSMR=3.
- Accepts one high-level request: bus id, 7-bit slave address, direction, byte count. Issues SET_BUS, START, address byte, data bytes and STOP, streaming data in and out.
- Uses irq_i plus a CMDR read to detect each command completion. Reports one completion status per request.
- Sits between the test/system controller and the iicmb Wishbone slave port.

---
 rtl/i2c_xfer_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_i2c_xfer_sequencer.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: Wishbone master that drives the iicmb register file
// (CSR/DPR/CMDR) to run one complete I2C transaction per request.
// Each command is written to CMDR, then the block waits for irq_i and reads
// CMDR back to decode don/nak/al/err. A single completion status is
// reported when the transaction ends.

module i2c_xfer_sequencer #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [3:0]            req_bus,
    input  logic [6:0]            req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [7:0]            wdata,
    output logic                  rdata_valid,
    output logic [7:0]            rdata,
    output logic                  done_valid,
    output logic [2:0]            done_status,
    output logic [LEN_W-1:0]      done_count,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  irq_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [ADDR_WIDTH-1:0] ADR_CSR  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADR_DPR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADR_CMDR = ADDR_WIDTH'(2);

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_RD_ACK = 8'h02;
    localparam logic [7:0] CMD_RD_NAK = 8'h03;
    localparam logic [7:0] CMD_START  = 8'h04;
    localparam logic [7:0] CMD_STOP   = 8'h05;
    localparam logic [7:0] CMD_SETBUS = 8'h06;

    localparam logic [2:0] STAT_OK      = 3'd0;
    localparam logic [2:0] STAT_NAK     = 3'd1;
    localparam logic [2:0] STAT_ARBLOST = 3'd2;
    localparam logic [2:0] STAT_ERR     = 3'd3;
    localparam logic [2:0] STAT_TIMEOUT = 3'd4;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_DPR_WR,
        ST_CMD_WR,
        ST_WAIT_IRQ,
        ST_CMD_RD,
        ST_GET_WDATA,
        ST_DPR_RD,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_SETBUS,
        PH_START,
        PH_ADDR,
        PH_DATA,
        PH_STOP
    } phase_t;

    state_t                state_q, state_n;
    phase_t                phase_q, phase_n;
    logic                  rw_q, rw_n;
    logic [6:0]            addr_q, addr_n;
    logic [LEN_W-1:0]      len_q, len_n;
    logic [LEN_W-1:0]      count_q, count_n;
    logic [2:0]            status_q, status_n;
    logic [7:0]            cmd_q, cmd_n;
    logic [7:0]            dpr_q, dpr_n;
    logic [TW-1:0]         tcnt_q, tcnt_n;
    logic                  cyc_q, cyc_n;
    logic                  stb_q, stb_n;
    logic                  we_q, we_n;
    logic [ADDR_WIDTH-1:0] adr_q, adr_n;
    logic [DATA_WIDTH-1:0] dat_q, dat_n;
    logic [7:0]            rdata_q, rdata_n;
    logic                  rvalid_q, rvalid_n;

    logic                  acc_req;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [DATA_WIDTH-1:0] acc_dat;
    logic                  acc_done;
    logic [LEN_W-1:0]      count_inc;
    logic [7:0]            cmdr_stat;

    assign acc_done  = cyc_q & ack_i;
    assign count_inc = count_q + LEN_W'(1);
    assign cmdr_stat = dat_i[7:0];

    assign req_ready   = (state_q == ST_IDLE);
    assign done_valid  = (state_q == ST_DONE);
    assign done_status = done_valid ? status_q : 3'd0;
    assign done_count  = done_valid ? count_q : '0;
    assign rdata_valid = rvalid_q;
    assign rdata       = rdata_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;

    // Register all sequencer state and Wishbone outputs; reset drops the bus at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_INIT;
            phase_q  <= PH_SETBUS;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            count_q  <= '0;
            status_q <= STAT_OK;
            cmd_q    <= '0;
            dpr_q    <= '0;
            tcnt_q   <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            phase_q  <= phase_n;
            rw_q     <= rw_n;
            addr_q   <= addr_n;
            len_q    <= len_n;
            count_q  <= count_n;
            status_q <= status_n;
            cmd_q    <= cmd_n;
            dpr_q    <= dpr_n;
            tcnt_q   <= tcnt_n;
            cyc_q    <= cyc_n;
            stb_q    <= stb_n;
            we_q     <= we_n;
            adr_q    <= adr_n;
            dat_q    <= dat_n;
            rdata_q  <= rdata_n;
            rvalid_q <= rvalid_n;
        end
    end

    // Next-state, transaction sequencing and the single-beat Wishbone access engine.
    always_comb begin
        state_n     = state_q;
        phase_n     = phase_q;
        rw_n        = rw_q;
        addr_n      = addr_q;
        len_n       = len_q;
        count_n     = count_q;
        status_n    = status_q;
        cmd_n       = cmd_q;
        dpr_n       = dpr_q;
        tcnt_n      = tcnt_q;
        rdata_n     = rdata_q;
        rvalid_n    = 1'b0;
        wdata_ready = 1'b0;
        acc_req     = 1'b0;
        acc_we      = 1'b0;
        acc_adr     = ADR_CSR;
        acc_dat     = '0;

        case (state_q)
            ST_INIT: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CSR;
                acc_dat = DATA_WIDTH'(8'hC0);
                if (acc_done) state_n = ST_IDLE;
            end

            ST_IDLE: begin
                if (req_valid) begin
                    rw_n     = req_rw;
                    addr_n   = req_addr;
                    len_n    = req_len;
                    count_n  = '0;
                    status_n = STAT_OK;
                    phase_n  = PH_SETBUS;
                    dpr_n    = {4'h0, req_bus};
                    cmd_n    = CMD_SETBUS;
                    state_n  = ST_DPR_WR;
                end
            end

            ST_DPR_WR: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_DPR;
                acc_dat = DATA_WIDTH'(dpr_q);
                if (acc_done) state_n = ST_CMD_WR;
            end

            ST_CMD_WR: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = DATA_WIDTH'(cmd_q);
                if (acc_done) begin
                    tcnt_n  = '0;
                    state_n = ST_WAIT_IRQ;
                end
            end

            ST_WAIT_IRQ: begin
                if (irq_i) begin
                    state_n = ST_CMD_RD;
                end else if (tcnt_q == TO_LAST) begin
                    status_n = STAT_TIMEOUT;
                    state_n  = ST_DONE;
                end else begin
                    tcnt_n = tcnt_q + TW'(1);
                end
            end

            ST_CMD_RD: begin
                acc_req = 1'b1;
                acc_adr = ADR_CMDR;
                if (acc_done) begin
                    if (cmdr_stat[5]) begin
                        if (status_q == STAT_OK) status_n = STAT_ARBLOST;
                        state_n = ST_DONE;
                    end else if (cmdr_stat[4]) begin
                        if (status_q == STAT_OK) status_n = STAT_ERR;
                        state_n = ST_DONE;
                    end else if (cmdr_stat[6]) begin
                        if (phase_q == PH_STOP) begin
                            state_n = ST_DONE;
                        end else begin
                            status_n = STAT_NAK;
                            phase_n  = PH_STOP;
                            cmd_n    = CMD_STOP;
                            state_n  = ST_CMD_WR;
                        end
                    end else if (cmdr_stat[7]) begin
                        case (phase_q)
                            PH_SETBUS: begin
                                phase_n = PH_START;
                                cmd_n   = CMD_START;
                                state_n = ST_CMD_WR;
                            end
                            PH_START: begin
                                phase_n = PH_ADDR;
                                dpr_n   = {addr_q, rw_q};
                                cmd_n   = CMD_WRITE;
                                state_n = ST_DPR_WR;
                            end
                            PH_ADDR: begin
                                if (len_q == '0) begin
                                    phase_n = PH_STOP;
                                    cmd_n   = CMD_STOP;
                                    state_n = ST_CMD_WR;
                                end else if (rw_q) begin
                                    phase_n = PH_DATA;
                                    cmd_n   = (len_q == LEN_W'(1)) ? CMD_RD_NAK : CMD_RD_ACK;
                                    state_n = ST_CMD_WR;
                                end else begin
                                    phase_n = PH_DATA;
                                    state_n = ST_GET_WDATA;
                                end
                            end
                            PH_DATA: begin
                                if (rw_q) begin
                                    state_n = ST_DPR_RD;
                                end else begin
                                    count_n = count_inc;
                                    if (count_inc == len_q) begin
                                        phase_n = PH_STOP;
                                        cmd_n   = CMD_STOP;
                                        state_n = ST_CMD_WR;
                                    end else begin
                                        state_n = ST_GET_WDATA;
                                    end
                                end
                            end
                            PH_STOP: begin
                                state_n = ST_DONE;
                            end
                            default: begin
                                state_n = ST_DONE;
                            end
                        endcase
                    end else begin
                        if (status_q == STAT_OK) status_n = STAT_ERR;
                        state_n = ST_DONE;
                    end
                end
            end

            ST_GET_WDATA: begin
                wdata_ready = wdata_valid;
                if (wdata_valid) begin
                    dpr_n   = wdata;
                    cmd_n   = CMD_WRITE;
                    state_n = ST_DPR_WR;
                end
            end

            ST_DPR_RD: begin
                acc_req = 1'b1;
                acc_adr = ADR_DPR;
                if (acc_done) begin
                    rdata_n  = dat_i[7:0];
                    rvalid_n = 1'b1;
                    count_n  = count_inc;
                    if (count_inc == len_q) begin
                        phase_n = PH_STOP;
                        cmd_n   = CMD_STOP;
                    end else begin
                        cmd_n = (count_inc == len_q - LEN_W'(1)) ? CMD_RD_NAK : CMD_RD_ACK;
                    end
                    state_n = ST_CMD_WR;
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_INIT;
            end
        endcase

        cyc_n = cyc_q;
        stb_n = stb_q;
        we_n  = we_q;
        adr_n = adr_q;
        dat_n = dat_q;
        if (acc_done) begin
            cyc_n = 1'b0;
            stb_n = 1'b0;
            we_n  = 1'b0;
            adr_n = '0;
            dat_n = '0;
        end else if (acc_req && !cyc_q) begin
            cyc_n = 1'b1;
            stb_n = 1'b1;
            we_n  = acc_we;
            adr_n = acc_adr;
            dat_n = acc_dat;
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer: scoreboard bench with an iicmb register-file model.
// Expected Wishbone accesses, read bytes and completions are queued when a
// request is issued and compared as the sequencer produces them.

module tb_i2c_xfer_sequencer;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rw = 1'b0;
    logic [3:0]    req_bus = '0;
    logic [6:0]    req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [7:0]    wdata;
    logic          rdata_valid;
    logic [7:0]    rdata;
    logic          done_valid;
    logic [2:0]    done_status;
    logic [LW-1:0] done_count;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic          ack_i;
    logic [DW-1:0] dat_i;
    logic          irq_i;

    i2c_xfer_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .done_valid(done_valid), .done_status(done_status), .done_count(done_count),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle_cnt = 0;

    logic [10:0] exp_acc[$];
    logic [7:0]  exp_rdata[$];
    logic [10:0] exp_done[$];
    logic [7:0]  rd_src[$];
    logic [7:0]  wsrc[$];

    int   nak_idx = -1;
    bit   al_on_start = 1'b0;
    bit   irq_never = 1'b0;
    int   wr_idx = 0;
    int   irq_timer = 0;
    int   last_cmdwr_edge = 0;
    int   wr_pulses = 0;
    int   done_seen = 0;
    logic [7:0] cmd_resp = 8'h80;

    initial forever begin
        @(posedge clk_i);
        cycle_cnt++;
    end

    // iicmb register file model: acks every access one cycle later and checks it against the scoreboard
    initial begin
        logic [10:0] e;
        ack_i = 1'b0;
        dat_i = '0;
        irq_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                ack_i = 1'b0;
                irq_i = 1'b0;
                irq_timer = 0;
            end else begin
                if (irq_timer > 0) begin
                    irq_timer--;
                    if (irq_timer == 0) irq_i = 1'b1;
                end
                if (ack_i) begin
                    ack_i = 1'b0;
                end else if (cyc_o && stb_o) begin
                    ack_i = 1'b1;
                    dat_i = '0;
                    tests_run++;
                    if (exp_acc.size() == 0) begin
                        tests_failed++;
                        $display("[TB] FAIL wb_access: unexpected access we=%0b adr=%0d dat=%02h, none required",
                                 we_o, adr_o, dat_o);
                    end else begin
                        e = exp_acc.pop_front();
                        if ({we_o, adr_o} !== e[10:8] || (we_o && dat_o !== e[7:0])) begin
                            tests_failed++;
                            $display("[TB] FAIL wb_access: got we=%0b adr=%0d dat=%02h, required we=%0b adr=%0d dat=%02h",
                                     we_o, adr_o, dat_o, e[10], e[9:8], e[7:0]);
                        end
                    end
                    if (we_o && adr_o == 2'd2) begin
                        last_cmdwr_edge = cycle_cnt + 1;
                        case (dat_o)
                            8'h04: begin
                                cmd_resp = al_on_start ? 8'h20 : 8'h80;
                                wr_idx = 0;
                            end
                            8'h01: begin
                                cmd_resp = (wr_idx == nak_idx) ? 8'h40 : 8'h80;
                                wr_idx++;
                            end
                            default: cmd_resp = 8'h80;
                        endcase
                        if (!irq_never) irq_timer = 3;
                    end
                    if (!we_o && adr_o == 2'd2) begin
                        dat_i = cmd_resp;
                        irq_i = 1'b0;
                    end
                    if (!we_o && adr_o == 2'd1) begin
                        dat_i = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                    end
                end
            end
        end
    end

    // Write-byte source: presents queued bytes and retires one per wdata_valid/wdata_ready handshake
    initial begin
        bit hs;
        wdata_valid = 1'b0;
        wdata = '0;
        forever begin
            @(negedge clk_i);
            hs = wdata_valid && wdata_ready;
            @(posedge clk_i);
            #1;
            if (hs && wsrc.size() > 0) begin
                void'(wsrc.pop_front());
                wr_pulses++;
            end
            wdata_valid = (wsrc.size() > 0);
            wdata = (wsrc.size() > 0) ? wsrc[0] : 8'h00;
        end
    end

    // Output monitor: compares read-byte pulses and completion pulses against queued expectations
    initial begin
        logic [7:0]  er;
        logic [10:0] ed;
        forever begin
            @(negedge clk_i);
            if (rdata_valid) begin
                tests_run++;
                if (exp_rdata.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL rdata: unexpected pulse rdata=%02h", rdata);
                end else begin
                    er = exp_rdata.pop_front();
                    if (rdata !== er) begin
                        tests_failed++;
                        $display("[TB] FAIL rdata: got %02h, required %02h", rdata, er);
                    end
                end
            end
            if (done_valid) begin
                done_seen++;
                tests_run++;
                if (exp_done.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL done: unexpected pulse status=%0d count=%0d", done_status, done_count);
                end else begin
                    ed = exp_done.pop_front();
                    if ({done_status, done_count} !== ed) begin
                        tests_failed++;
                        $display("[TB] FAIL done: got status=%0d count=%0d, required status=%0d count=%0d",
                                 done_status, done_count, ed[10:8], ed[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got no end, required end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
        exp_acc.push_back({1'b1, a, d});
    endtask

    task automatic push_rd(input logic [1:0] a);
        exp_acc.push_back({1'b0, a, 8'h00});
    endtask

    task automatic push_cmd(input logic [7:0] c);
        push_wr(2'd2, c);
        push_rd(2'd2);
    endtask

    task automatic push_prologue(input logic [3:0] bus, input logic [6:0] addr, input logic rw);
        push_wr(2'd1, {4'h0, bus});
        push_cmd(8'h06);
        push_cmd(8'h04);
        push_wr(2'd1, {addr, rw});
        push_cmd(8'h01);
    endtask

    task automatic drive_req(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                             input logic [LW-1:0] len);
        bit seen;
        seen = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid = 1'b1;
        req_rw = rw;
        req_bus = bus;
        req_addr = addr;
        req_len = len;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk_i);
            if (req_ready) seen = 1'b1;
        end
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL req_accept: got req_ready=0 for 500 cycles, required 1");
        end
    endtask

    task automatic wait_done(input int start);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk_i);
            if (done_seen > start) seen = 1'b1;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_wait: got no done_valid in 2000 cycles, required one");
        end
    endtask

    task automatic test_reset;
        bit seen;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wdata_ready, rdata_valid, rdata,
             done_valid, done_status, done_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got cyc=%0b stb=%0b we=%0b adr=%0d dat=%02h rdy=%0b dv=%0b, required all 0",
                     cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, done_valid);
        end
        push_wr(2'd0, 8'hC0);
        rst_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (req_ready) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL init_ready: got req_ready=0, required 1 after INIT");
        end
        tests_run++;
        if (exp_acc.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL init_access: got %0d accesses missing, required 0", exp_acc.size());
        end
    endtask

    task automatic test_write;
        int d0, p0;
        push_prologue(4'd2, 7'h22, 1'b0);
        push_wr(2'd1, 8'hAA); push_cmd(8'h01);
        push_wr(2'd1, 8'h55); push_cmd(8'h01);
        push_wr(2'd1, 8'h01); push_cmd(8'h01);
        push_cmd(8'h05);
        exp_done.push_back({3'd0, 8'd3});
        wsrc.push_back(8'hAA); wsrc.push_back(8'h55); wsrc.push_back(8'h01);
        d0 = done_seen;
        p0 = wr_pulses;
        drive_req(1'b0, 4'd2, 7'h22, 8'd3);
        wait_done(d0);
        tests_run++;
        if (exp_acc.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL write_access_left: got %0d accesses missing, required 0", exp_acc.size());
        end
        tests_run++;
        if (wr_pulses - p0 != 3) begin
            tests_failed++;
            $display("[TB] FAIL write_pulses: got %0d wdata_ready pulses, required 3", wr_pulses - p0);
        end
    endtask

    task automatic test_read;
        int d0;
        push_prologue(4'd1, 7'h22, 1'b1);
        push_cmd(8'h02); push_rd(2'd1);
        push_cmd(8'h03); push_rd(2'd1);
        push_cmd(8'h05);
        rd_src.push_back(8'h12); rd_src.push_back(8'h34);
        exp_rdata.push_back(8'h12); exp_rdata.push_back(8'h34);
        exp_done.push_back({3'd0, 8'd2});
        d0 = done_seen;
        drive_req(1'b1, 4'd1, 7'h22, 8'd2);
        wait_done(d0);
        tests_run++;
        if (exp_acc.size() != 0 || exp_rdata.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL read_left: got %0d accesses and %0d bytes missing, required 0 and 0",
                     exp_acc.size(), exp_rdata.size());
        end
    endtask

    task automatic test_nak;
        int d0, p0;
        nak_idx = 2;
        push_prologue(4'd3, 7'h50, 1'b0);
        push_wr(2'd1, 8'h11); push_cmd(8'h01);
        push_wr(2'd1, 8'h22); push_cmd(8'h01);
        push_cmd(8'h05);
        exp_done.push_back({3'd1, 8'd1});
        wsrc.push_back(8'h11); wsrc.push_back(8'h22); wsrc.push_back(8'h33); wsrc.push_back(8'h44);
        d0 = done_seen;
        p0 = wr_pulses;
        drive_req(1'b0, 4'd3, 7'h50, 8'd4);
        wait_done(d0);
        repeat (4) @(negedge clk_i);
        tests_run++;
        if (wr_pulses - p0 != 2) begin
            tests_failed++;
            $display("[TB] FAIL nak_pulses: got %0d wdata_ready pulses, required 2", wr_pulses - p0);
        end
        tests_run++;
        if (exp_acc.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL nak_access_left: got %0d accesses missing, required 0", exp_acc.size());
        end
        wsrc.delete();
        nak_idx = -1;
    endtask

    task automatic test_arb_lost;
        bit seen;
        al_on_start = 1'b1;
        push_wr(2'd1, 8'h04);
        push_cmd(8'h06);
        push_cmd(8'h04);
        exp_done.push_back({3'd2, 8'd0});
        drive_req(1'b0, 4'd4, 7'h10, 8'd2);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk_i);
            if (done_valid) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL al_done_wait: got no done_valid, required one");
        end
        @(negedge clk_i);
        tests_run++;
        if (req_ready !== 1'b1 || done_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL al_ready_after: got req_ready=%0b done_valid=%0b, required 1 and 0",
                     req_ready, done_valid);
        end
        tests_run++;
        if (exp_acc.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL al_access_left: got %0d accesses missing, required 0", exp_acc.size());
        end
        al_on_start = 1'b0;
    endtask

    task automatic test_timeout;
        bit seen;
        int done_edge;
        irq_never = 1'b1;
        push_wr(2'd1, 8'h05);
        push_wr(2'd2, 8'h06);
        exp_done.push_back({3'd4, 8'd0});
        drive_req(1'b0, 4'd5, 7'h33, 8'd1);
        seen = 1'b0;
        done_edge = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk_i);
            if (done_valid) begin
                seen = 1'b1;
                done_edge = cycle_cnt;
            end
        end
        tests_run++;
        if (!seen || done_edge - last_cmdwr_edge != 16) begin
            tests_failed++;
            $display("[TB] FAIL timeout_latency: got %0d cycles (seen=%0b), required 16",
                     done_edge - last_cmdwr_edge, seen);
        end
        tests_run++;
        if (exp_acc.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_access_left: got %0d accesses missing, required 0", exp_acc.size());
        end
        irq_never = 1'b0;
    endtask

    task automatic test_probe;
        int d0;
        push_prologue(4'd6, 7'h7F, 1'b1);
        push_cmd(8'h05);
        exp_done.push_back({3'd0, 8'd0});
        d0 = done_seen;
        drive_req(1'b1, 4'd6, 7'h7F, 8'd0);
        wait_done(d0);
        tests_run++;
        if (exp_acc.size() != 0 || exp_rdata.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL probe_left: got %0d accesses missing, required 0", exp_acc.size());
        end
    endtask

    task automatic test_reset_mid;
        int d0, p0;
        bit seen;
        push_prologue(4'd2, 7'h22, 1'b0);
        push_wr(2'd1, 8'hAA);
        wsrc.push_back(8'hAA); wsrc.push_back(8'h55);
        d0 = done_seen;
        p0 = wr_pulses;
        drive_req(1'b0, 4'd2, 7'h22, 8'd2);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk_i);
            if (wr_pulses > p0) seen = 1'b1;
        end
        @(posedge clk_i);
        #3;
        tests_run++;
        if (!seen || cyc_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pre: got cyc_o=%0b seen=%0b, required cyc_o=1 during data byte",
                     cyc_o, seen);
        end
        rst_i = 1'b0;
        #1;
        tests_run++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_bus: got cyc=%0b stb=%0b we=%0b adr=%0d dat=%02h, required all 0",
                     cyc_o, stb_o, we_o, adr_o, dat_o);
        end
        wsrc.delete();
        push_wr(2'd0, 8'hC0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (req_ready) seen = 1'b1;
        end
        repeat (10) @(negedge clk_i);
        tests_run++;
        if (!seen || exp_acc.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_init: got ready=%0b, %0d accesses missing, required 1 and 0",
                     seen, exp_acc.size());
        end
        tests_run++;
        if (done_seen != d0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done: got %0d done pulses, required 0", done_seen - d0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_arb_lost();
        test_timeout();
        test_probe();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
